pwl_step_sequencer: RTL and testbench

- Clocked scheduler that drives the `in`/`en` pins of a downstream real-to-PWL converter from a queue of (level, dwell) setpoints.
- Guarantees that consecutive level changes are at least TR_CYC clock cycles apart, so the converter's transition time is never violated.
- Sits between digital test/control logic and the PWL analog-behavioural datapath; the ramp itself stays in the converter.

---
 rtl/pwl_step_sequencer_pkg.sv | 30 +++
 rtl/pwl_step_sequencer_if.sv | 33 +++
 rtl/pwl_step_sequencer_fifo.sv | 62 ++++++
 rtl/pwl_step_sequencer.sv | 114 +++++++++++
 tb/tb_pwl_step_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pwl_step_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwl_seq_pkg
// Brief    : Shared types and the dwell clamp for the PWL step sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pwl_seq_pkg;

    parameter int DWELL_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } seq_state_t;

    typedef struct {
        real                level;
        logic [DWELL_W-1:0] dwell;
    } seq_entry_t;

    // A level change must never arrive faster than the converter can ramp.
    function automatic logic [DWELL_W-1:0] eff_dwell(
        input logic [DWELL_W-1:0] dwell,
        input logic [DWELL_W-1:0] tr_cyc
    );
        return (dwell < tr_cyc) ? tr_cyc : dwell;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwl_step_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pwl_step_sequencer_if
// Brief    : Setpoint push, control and converter-drive signals of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pwl_step_sequencer_if #(
    parameter int DEPTH   = 4,
    parameter int DWELL_W = 16
);
    logic                         push;
    real                          push_level;
    logic [DWELL_W-1:0]           push_dwell;
    logic                         push_ready;
    logic                         start;
    logic                         abort;
    real                          level_out;
    logic                         en_out;
    logic                         busy;
    logic                         done;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output push, push_level, push_dwell, start, abort,
        input  push_ready, level_out, en_out, busy, done, count
    );

    modport slave (
        input  push, push_level, push_dwell, start, abort,
        output push_ready, level_out, en_out, busy, done, count
    );
endinterface
`default_nettype wire

// File: rtl/pwl_step_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pwl_seq_fifo
// Brief    : Synchronous setpoint FIFO with flush; full pushes are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module pwl_seq_fifo
    import pwl_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push,
    input  seq_entry_t                      push_entry,
    output logic                            push_ready,
    input  wire logic                       pop,
    output seq_entry_t                      head,
    input  wire logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0]      count
);
    localparam int                c_ptr_w = $clog2(DEPTH);
    localparam int                c_cnt_w = $clog2(DEPTH+1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    seq_entry_t          r_mem [DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                w_wr;
    logic                w_rd;

    assign push_ready = (r_count < c_depth);
    assign w_wr       = push && push_ready && !flush;
    assign w_rd       = pop && (r_count != '0) && !flush;
    assign head       = r_mem[r_rd_ptr];
    assign count      = r_count;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/pwl_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwl_step_sequencer
// Brief    : Plays queued (level, dwell) setpoints into a real-to-PWL converter.
// Revision : 1.0 - initial release
// ============================================================================
module pwl_step_sequencer #(
    parameter int DEPTH   = 4,
    parameter int DWELL_W = 16,
    parameter int TR_CYC  = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pwl_step_sequencer_if.slave   bus
);
    localparam logic [DWELL_W-1:0] c_tr_cyc = DWELL_W'(TR_CYC);
    localparam logic [DWELL_W-1:0] c_one    = DWELL_W'(1);

    pwl_seq_pkg::seq_state_t     r_state;
    pwl_seq_pkg::seq_state_t     w_state_nxt;
    pwl_seq_pkg::seq_entry_t     w_push_entry;
    pwl_seq_pkg::seq_entry_t     w_head;
    logic [DWELL_W-1:0]          r_hold_cnt;
    real                         r_level;
    logic                        r_en;
    logic                        r_done;
    logic                        w_pop;
    logic                        w_done_nxt;
    logic                        w_has_entry;
    logic                        w_last_cycle;
    logic [$clog2(DEPTH+1)-1:0]  w_count;

    always_comb begin
        w_push_entry.level = bus.push_level;
        w_push_entry.dwell = bus.push_dwell;
    end

    pwl_seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (bus.push),
        .push_entry (w_push_entry),
        .push_ready (bus.push_ready),
        .pop        (w_pop),
        .head       (w_head),
        .flush      (bus.abort),
        .count      (w_count)
    );

    assign w_has_entry  = (w_count != '0);
    assign w_last_cycle = (r_hold_cnt == c_one);

    always_ff @(posedge clk) begin
        if (rst) r_state <= pwl_seq_pkg::IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done_nxt  = 1'b0;
        if (bus.abort) begin
            w_state_nxt = pwl_seq_pkg::IDLE;
        end else begin
            case (r_state)
                pwl_seq_pkg::IDLE: begin
                    if (bus.start && w_has_entry) begin
                        w_pop       = 1'b1;
                        w_state_nxt = pwl_seq_pkg::HOLD;
                    end
                end
                pwl_seq_pkg::HOLD: begin
                    // Back-to-back reload on the last cycle keeps the output gap-free.
                    if (w_last_cycle) begin
                        if (w_has_entry) begin
                            w_pop = 1'b1;
                        end else begin
                            w_state_nxt = pwl_seq_pkg::IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = pwl_seq_pkg::IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            r_level    <= 0.0;
            r_en       <= 1'b0;
            r_hold_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_pop) begin
                r_level    <= w_head.level;
                r_en       <= 1'b1;
                r_hold_cnt <= pwl_seq_pkg::eff_dwell(w_head.dwell, c_tr_cyc);
            end else if (r_state == pwl_seq_pkg::HOLD) begin
                r_hold_cnt <= r_hold_cnt - c_one;
            end
        end
    end

    assign bus.level_out = r_level;
    assign bus.en_out    = r_en;
    assign bus.busy      = (r_state == pwl_seq_pkg::HOLD);
    assign bus.done      = r_done;
    assign bus.count     = w_count;
endmodule
`default_nettype wire

// File: tb/tb_pwl_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwl_step_sequencer
// Brief    : Directed self-checking bench for pwl_step_sequencer (DEPTH=4, TR_CYC=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwl_step_sequencer;
    logic clk;
    logic rst;
    int   err_cnt;
    int   chk_cnt;

    pwl_step_sequencer_if #(.DEPTH(4), .DWELL_W(16)) bus ();

    pwl_step_sequencer #(
        .DEPTH   (4),
        .DWELL_W (16),
        .TR_CYC  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input real got, input real exp);
        real diff;
        chk_cnt++;
        diff = got - exp;
        if (diff < 0.0) diff = -diff;
        if (diff > 1.0e-9) begin
            err_cnt++;
            $display("FAIL %s: got %f expected %f", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input real lvl, input int dw);
        bus.push       = 1'b1;
        bus.push_level = lvl;
        bus.push_dwell = 16'(dw);
        tick();
        bus.push       = 1'b0;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_level"},      bus.level_out,  0.0);
        check({pfx, "_en"},         bus.en_out,     0.0);
        check({pfx, "_busy"},       bus.busy,       0.0);
        check({pfx, "_done"},       bus.done,       0.0);
        check({pfx, "_count"},      bus.count,      0.0);
        check({pfx, "_push_ready"}, bus.push_ready, 1.0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        err_cnt        = 0;
        chk_cnt        = 0;
        rst            = 1'b1;
        bus.push       = 1'b0;
        bus.push_level = 0.0;
        bus.push_dwell = '0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;

        // Reset
        repeat (3) tick();
        check_reset("rst");
        rst = 1'b0;
        tick();

        // Two entries, no clamp: 10 cycles of 0.5 then 6 of 1.2
        push_one(0.5, 10);
        push_one(1.2, 6);
        check("t2_count", bus.count, 2.0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("t2_lvl_c%0d", i), bus.level_out, (i <= 10) ? 0.5 : 1.2);
            check($sformatf("t2_done_c%0d", i), bus.done, 0.0);
            check($sformatf("t2_busy_c%0d", i), bus.busy, 1.0);
            tick();
        end
        check("t2_done_pulse", bus.done, 1.0);
        check("t2_busy_end", bus.busy, 0.0);
        check("t2_en_held", bus.en_out, 1.0);
        check("t2_lvl_held", bus.level_out, 1.2);
        tick();
        check("t2_done_clear", bus.done, 0.0);

        // Short dwells clamp to TR_CYC
        push_one(0.8, 1);
        push_one(0.3, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("t3_lvl_c%0d", i), bus.level_out, (i <= 4) ? 0.8 : 0.3);
            check($sformatf("t3_done_c%0d", i), bus.done, 0.0);
            tick();
        end
        check("t3_done_pulse", bus.done, 1.0);
        check("t3_busy_end", bus.busy, 0.0);
        tick();

        // Fill to full; fifth push and push-at-pop are both lost
        push_one(0.1, 0);
        push_one(0.2, 0);
        push_one(0.3, 0);
        check("t4_ready_3", bus.push_ready, 1.0);
        push_one(0.4, 0);
        check("t4_ready_full", bus.push_ready, 0.0);
        check("t4_count_full", bus.count, 4.0);
        push_one(0.45, 0);
        check("t4_count_5th", bus.count, 4.0);
        bus.start      = 1'b1;
        bus.push       = 1'b1;
        bus.push_level = 0.9;
        bus.push_dwell = 16'd0;
        tick();
        bus.start = 1'b0;
        bus.push  = 1'b0;
        check("t4_count_pop", bus.count, 3.0);
        check("t4_lvl_c1", bus.level_out, 0.1);
        repeat (4) tick();
        check("t4_lvl_c5", bus.level_out, 0.2);
        repeat (8) tick();
        check("t4_lvl_c13", bus.level_out, 0.4);
        check("t4_done_c13", bus.done, 0.0);
        repeat (4) tick();
        check("t4_done_c17", bus.done, 1.0);
        check("t4_count_end", bus.count, 0.0);
        tick();

        // Abort in the 3rd HOLD cycle with two entries queued
        push_one(0.5, 10);
        push_one(0.7, 4);
        push_one(0.6, 4);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("t5_count_pre", bus.count, 2.0);
        bus.abort      = 1'b1;
        bus.push       = 1'b1;
        bus.push_level = 0.25;
        bus.push_dwell = 16'd5;
        tick();
        bus.abort = 1'b0;
        bus.push  = 1'b0;
        check("t5_level", bus.level_out, 0.0);
        check("t5_en", bus.en_out, 0.0);
        check("t5_count", bus.count, 0.0);
        check("t5_busy", bus.busy, 0.0);
        check("t5_done", bus.done, 0.0);
        tick();
        check("t5_done_next", bus.done, 0.0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t5_empty_busy", bus.busy, 0.0);
        check("t5_empty_en", bus.en_out, 0.0);
        tick();
        check("t5_empty_done", bus.done, 0.0);

        // Push during HOLD extends the sequence with no gap; then reset mid-HOLD
        push_one(0.5, 10);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        push_one(0.9, 5);
        check("t6_count_ext", bus.count, 1.0);
        repeat (4) tick();
        check("t6_lvl_c10", bus.level_out, 0.5);
        tick();
        check("t6_lvl_c11", bus.level_out, 0.9);
        check("t6_busy_c11", bus.busy, 1.0);
        check("t6_count_c11", bus.count, 0.0);
        rst = 1'b1;
        tick();
        check_reset("t6_rst");
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
`default_nettype wire
